// File: rtl/nand_addr_latch_cycle.sv
// nand_addr_latch_cycle
// Address latch cycle generator for the NAND flash test path. A start pulse
// latches a packed address. The address is then sent MSB byte first as
// ALE-qualified write cycles with programmable setup, strobe-low and
// strobe-high times. A level done flag is raised once the last byte is out.
//
// Build option: define NAND_ALC_5CYC_EN to add the addr_ext port and send a
// fifth address byte after addr_in[7:0]. Leave it undefined for four bytes.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start, bus released
// SETUP  | byte on io_out with ALE high, we_n high (address setup time)
// WLOW   | we_n driven low, byte and ALE held
// WHIGH  | we_n back high, byte and ALE held (hold time after rising edge)
// DONE   | sequence complete, done high until the next accepted start

module nand_addr_latch_cycle #(
  parameter int unsigned TSETUP = 1,
  parameter int unsigned TWP    = 2,
  parameter int unsigned TWH    = 2
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] addr_in,
`ifdef NAND_ALC_5CYC_EN
  input  logic [7:0]  addr_ext,
`endif
  output logic [7:0]  io_out,
  output logic        io_oe,
  output logic        ale,
  output logic        we_n,
  output logic        busy,
  output logic        done
);

`ifdef NAND_ALC_5CYC_EN
  localparam int unsigned NBYTES = 5;
`else
  localparam int unsigned NBYTES = 4;
`endif
  localparam int unsigned SREG_W = 8 * NBYTES;

  // Timer reload values; the timer counts down to zero inside each state.
  localparam logic [7:0] CNT_SETUP = 8'(TSETUP - 1);
  localparam logic [7:0] CNT_WLOW  = 8'(TWP - 1);
  localparam logic [7:0] CNT_WHIGH = 8'(TWH - 1);
  localparam logic [2:0] IDX_LAST  = 3'(NBYTES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_WLOW,
    ST_WHIGH,
    ST_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [SREG_W-1:0] sreg_q, sreg_d;
  logic [SREG_W-1:0] sreg_load;

  logic [7:0]        io_out_q, io_out_d;
  logic              io_oe_q, io_oe_d;
  logic              ale_q, ale_d;
  logic              we_n_q, we_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              active_d;

`ifdef NAND_ALC_5CYC_EN
  assign sreg_load = {addr_in, addr_ext};
`else
  assign sreg_load = addr_in;
`endif

  // Next-state, timer, byte index and shift register; start is only honoured
  // while the bus is idle so a running sequence cannot be corrupted.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sreg_d  = sreg_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          sreg_d  = sreg_load;
          idx_d   = 3'd0;
          cnt_d   = CNT_SETUP;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q == 8'd0) begin
          cnt_d   = CNT_WLOW;
          state_d = ST_WLOW;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_WLOW: begin
        if (cnt_q == 8'd0) begin
          cnt_d   = CNT_WHIGH;
          state_d = ST_WHIGH;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_WHIGH: begin
        if (cnt_q == 8'd0) begin
          if (idx_q == IDX_LAST) begin
            cnt_d   = 8'd0;
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 3'd1;
            sreg_d  = {sreg_q[SREG_W-9:0], 8'h00};
            cnt_d   = CNT_SETUP;
            state_d = ST_SETUP;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        cnt_d   = 8'd0;
        idx_d   = 3'd0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so that, once registered, they
  // line up with the state they describe and never see a combinational input.
  always_comb begin
    active_d = (state_d == ST_SETUP) || (state_d == ST_WLOW) ||
               (state_d == ST_WHIGH);
    busy_d   = active_d;
    ale_d    = active_d;
    io_oe_d  = active_d;
    we_n_d   = (state_d != ST_WLOW);
    done_d   = (state_d == ST_DONE);
    io_out_d = active_d ? sreg_d[SREG_W-1 -: 8] : 8'h00;
  end

  // Single state register; reset drops the strobe and releases the bus at once.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 8'd0;
      idx_q    <= 3'd0;
      sreg_q   <= '0;
      io_out_q <= 8'h00;
      io_oe_q  <= 1'b0;
      ale_q    <= 1'b0;
      we_n_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      sreg_q   <= sreg_d;
      io_out_q <= io_out_d;
      io_oe_q  <= io_oe_d;
      ale_q    <= ale_d;
      we_n_q   <= we_n_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign io_out = io_out_q;
  assign io_oe  = io_oe_q;
  assign ale    = ale_q;
  assign we_n   = we_n_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: doc/nand_addr_latch_cycle.md
# nand_addr_latch_cycle

Address latch cycle (ALC) generator for the NAND flash test path. It accepts the 32-bit packed address and a start pulse from the test controller. It serialises the address onto the 8-bit flash I/O bus as four ALE-qualified write cycles with programmable strobe timing. It then returns a level completion flag that the controller polls before issuing its next command.

## Interface
- TSETUP, 1: cycles `io_out`/ALE are stable before `we_n` falls (1..255)
- TWP, 2: cycles `we_n` is held low per byte (1..255)
- TWH, 2: cycles `we_n` is held high after rising, per byte (1..255)
- CLK  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  single-cycle request; driven by controller `rstALC`
- addr_in  in  32  packed address: [31:24] col1, [23:16] col2, [15:8] row1, [7:0] row2
- addr_ext  in  8  third row byte; port exists only with `NAND_ALC_5CYC_EN`
- io_out  out  8  byte driven to flash I/O[7:0]
- io_oe  out  1  I/O output enable
- ale  out  1  address latch enable to flash
- we_n  out  1  write enable strobe to flash, active-low
- busy  out  1  high while a sequence is in progress
- done  out  1  completion flag to controller `feedbackALC`

## Operation
- Reset values: `io_out`=8'h00, `io_oe`=0, `ale`=0, `we_n`=1, `busy`=0, `done`=0; state IDLE; byte index 0; timing counter 0.
- States: IDLE, SETUP, WLOW, WHIGH, DONE.
- IDLE: on `start`=1, `addr_in` is latched into a shift register and the byte index is cleared. The block goes to SETUP.
- SETUP: `io_oe`=1, `ale`=1, `we_n`=1, `io_out`=current byte. Stays TSETUP cycles, then goes to WLOW.
- WLOW: `we_n`=0 and data held. Stays TWP cycles, then goes to WHIGH.
- WHIGH: `we_n`=1 and data/ALE held, giving hold time after the rising edge. Stays TWH cycles. If bytes remain, the index increments and the block goes to SETUP; otherwise it goes to DONE.
- Byte order is MSB first: [31:24], [23:16], [15:8], [7:0].
- DONE: `done`=1, `busy`=0, `ale`=0, `io_oe`=0, `we_n`=1, `io_out`=8'h00. `done` holds until the next accepted `start`.
- `start` in DONE is accepted exactly as in IDLE. `done` clears on the same edge, and the new sequence begins.
- `start` in SETUP, WLOW or WHIGH is ignored. The latched address is not disturbed.
- `busy`=1 in SETUP, WLOW and WHIGH only.
- Timing counter is 8 bits, loaded with (param−1) on state entry and counting down to 0. It never wraps.
- Assertion of `reset` mid-sequence forces all reset values immediately (asynchronous). `we_n` returns high without completing the strobe. No `done` is produced.

## Timing
- `start` is sampled at edge E0. SETUP of byte 0 is visible from E0.
- Each byte occupies TSETUP+TWP+TWH cycles, with no gap between bytes.
- `done` rises after edge N·(TSETUP+TWP+TWH), where N=4 (N=5 with the macro). The defaults give edge 20.
- `we_n` low pulse is exactly TWP cycles. `ale` is continuously high from E0 to the end of the last WHIGH.
- Every output is registered, with no combinational path from inputs to outputs.

## Configuration
- `NAND_ALC_5CYC_EN` defined: the `addr_ext` port exists and is latched with `addr_in` on `start`. A fifth byte (`addr_ext`) is sent after [7:0], and N=5.
- `NAND_ALC_5CYC_EN` undefined: there is no `addr_ext` port, and four bytes are sent (N=4).

## Test plan
- Defaults, `addr_in`=32'hA5C3_0F81, one-cycle `start` -> `io_out` sequence A5, C3, 0F, 81. Each byte has a 2-cycle `we_n` low. `ale` is high throughout, and `done`=1 after edge 20.
- `start` pulsed again at edge 7 with `addr_in`=32'hFFFF_FFFF -> ignored. Bytes remain A5, C3, 0F, 81, and `done` timing is unchanged.
- `reset` asserted mid-WLOW of byte 2 -> on the same cycle `we_n`=1, `ale`=0, `io_oe`=0, `busy`=0, `done`=0. A subsequent `start` runs a full clean sequence.
- `done`=1 held for 10 cycles, then `start` with 32'h1234_5678 -> `done` clears on that edge and bytes 12, 34, 56, 78 are sent.
- TSETUP=2, TWP=1, TWH=1 -> per-byte period 4, `we_n` low 1 cycle, `done` after edge 16.
- `NAND_ALC_5CYC_EN` defined, `addr_ext`=8'h3C -> a fifth byte 3C is sent, and `done` rises after edge 25.
